// File: rtl/svf_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed state variable filter.
package svf_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BP   = 2'd1,
    S_LP   = 2'd2,
    S_DONE = 2'd3
  } svf_state_t;

  localparam int MODE_HP = 0;
  localparam int MODE_BP = 1;
  localparam int MODE_LP = 2;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    if (x > hi) return hi;
    if (x < -hi - 64'sd1) return -hi - 64'sd1;
    return x;
  endfunction

  // Scale a raw multiplier product by the frequency coefficient's fixed point (floor).
  function automatic logic signed [63:0] fmul_scale(input logic signed [63:0] prod,
                                                    input int alpha1_w);
    return prod >>> (alpha1_w + 3);
  endfunction

endpackage

// File: rtl/svf_core_alu.sv
// Combinational per-voice SVF arithmetic: hp/bp' in the BP phase, lp' and output mix in
// the LP phase, sharing one signed W x (ALPHA1_W+1) multiplier between the two phases.
module svf_core_alu
  import svf_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int FRAC_W   = 8,
  parameter int ALPHA1_W = 11,
  parameter int ALPHA2_W = 2,
  localparam int W = DATA_W + FRAC_W
) (
  input  logic                     lp_phase,
  input  logic signed [DATA_W-1:0] sample,
  input  logic [2:0]               mode,
  input  logic [ALPHA1_W-1:0]      alpha1,
  input  logic [ALPHA2_W-1:0]      alpha2,
  input  logic signed [W-1:0]      bp,
  input  logic signed [W-1:0]      lp,
  input  logic signed [W-1:0]      hp_reg,
  output logic signed [W-1:0]      hp,
  output logic signed [W-1:0]      state_new,
  output logic signed [DATA_W-1:0] mix_out
);

  localparam int XW = W + 2;

  logic signed [W-1:0]          in_s;
  logic signed [XW-1:0]         q_bp;
  logic signed [XW-1:0]         hp_sum;
  logic signed [W-1:0]          mul_a;
  logic signed [ALPHA1_W:0]     mul_b;
  logic signed [W+ALPHA1_W:0]   prod;
  logic signed [W-1:0]          step;
  logic signed [XW-1:0]         acc;
  logic signed [XW-1:0]         mix_sum;
  logic signed [W-1:0]          mix_w;

  always_comb begin
    in_s = {sample, {FRAC_W{1'b0}}};

    // Damping term: alpha2 MSB weights bp/2, next bit bp/4, and so on.
    q_bp = '0;
    for (int k = 0; k < ALPHA2_W; k++) begin
      if (alpha2[ALPHA2_W-1-k]) q_bp = q_bp + (XW'(bp) >>> (k + 1));
    end

    hp_sum = XW'(in_s) - XW'(lp) - q_bp;
    hp     = (W)'(sat_w(64'(hp_sum), W));

    mul_a = lp_phase ? bp : hp;
    mul_b = {1'b0, alpha1};
    prod  = mul_a * mul_b;
    step  = (W)'(fmul_scale(64'(prod), ALPHA1_W));

    acc       = XW'(lp_phase ? lp : bp) + XW'(step);
    state_new = (W)'(sat_w(64'(acc), W));

    // In the LP phase bp already holds bp' and state_new is lp'.
    mix_sum = '0;
    if (mode[MODE_HP]) mix_sum = mix_sum + XW'(hp_reg);
    if (mode[MODE_BP]) mix_sum = mix_sum + XW'(bp);
    if (mode[MODE_LP]) mix_sum = mix_sum + XW'(state_new);
    mix_w   = (W)'(sat_w(64'(mix_sum), W));
    mix_out = (mode == 3'b000) ? sample : mix_w[W-1:FRAC_W];
  end

endmodule

// File: rtl/svf_mux.sv
// Multi-voice Chamberlin SVF: one shared ALU walks every voice through a BP then LP step
// per accepted sample, then publishes all voice outputs together.
module svf_mux
  import svf_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FRAC_W     = 8,
  parameter int NUM_VOICES = 3,
  parameter int ALPHA1_W   = 11,
  parameter int ALPHA2_W   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_valid,
  input  logic [NUM_VOICES*DATA_W-1:0]   audio_in,
  input  logic [NUM_VOICES*3-1:0]        mode,
  input  logic [ALPHA1_W-1:0]            alpha1,
  input  logic [ALPHA2_W-1:0]            alpha2,
  output logic [NUM_VOICES*DATA_W-1:0]   audio_out,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           overrun
);

  localparam int W  = DATA_W + FRAC_W;
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  svf_state_t                  state;
  logic [VW-1:0]               v;
  logic signed [DATA_W-1:0]    in_sh    [NUM_VOICES];
  logic [2:0]                  mode_sh  [NUM_VOICES];
  logic [ALPHA1_W-1:0]         a1_sh;
  logic [ALPHA2_W-1:0]         a2_sh;
  logic signed [W-1:0]         bp_state [NUM_VOICES];
  logic signed [W-1:0]         lp_state [NUM_VOICES];
  logic signed [W-1:0]         hp_p1;
  logic [NUM_VOICES*DATA_W-1:0] out_sh;
  logic [NUM_VOICES*DATA_W-1:0] out_next;

  logic signed [W-1:0]         hp;
  logic signed [W-1:0]         state_new;
  logic signed [DATA_W-1:0]    mix_out;

  svf_core_alu #(
    .DATA_W   (DATA_W),
    .FRAC_W   (FRAC_W),
    .ALPHA1_W (ALPHA1_W),
    .ALPHA2_W (ALPHA2_W)
  ) u_alu (
    .lp_phase  (state == S_LP),
    .sample    (in_sh[v]),
    .mode      (mode_sh[v]),
    .alpha1    (a1_sh),
    .alpha2    (a2_sh),
    .bp        (bp_state[v]),
    .lp        (lp_state[v]),
    .hp_reg    (hp_p1),
    .hp        (hp),
    .state_new (state_new),
    .mix_out   (mix_out)
  );

  // The last voice's mix is merged in directly so all outputs appear in the DONE cycle.
  always_comb begin
    out_next = out_sh;
    out_next[int'(v)*DATA_W +: DATA_W] = mix_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      v         <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      audio_out <= '0;
      out_sh    <= '0;
      hp_p1     <= '0;
      a1_sh     <= '0;
      a2_sh     <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        in_sh[i]    <= '0;
        mode_sh[i]  <= '0;
        bp_state[i] <= '0;
        lp_state[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      overrun   <= sample_valid && busy;
      case (state)
        S_IDLE: begin
          if (sample_valid) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              in_sh[i]   <= $signed(audio_in[i*DATA_W +: DATA_W]);
              mode_sh[i] <= mode[i*3 +: 3];
            end
            a1_sh <= alpha1;
            a2_sh <= alpha2;
            v     <= '0;
            busy  <= 1'b1;
            state <= S_BP;
          end
        end
        // BP step: commit bp' and keep hp for the mix in the following LP step.
        S_BP: begin
          bp_state[v] <= state_new;
          hp_p1       <= hp;
          state       <= S_LP;
        end
        // LP step: commit lp' and this voice's output.
        S_LP: begin
          lp_state[v]                     <= state_new;
          out_sh[int'(v)*DATA_W +: DATA_W] <= mix_out;
          if (v == VW'(NUM_VOICES - 1)) begin
            audio_out <= out_next;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            v     <= v + 1'b1;
            state <= S_BP;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svf_mux.sv
// Bench for svf_mux: fixed vector table, hand-built overrun/reset sequences and random
// passes compared against an integer model of the filter equations.
module tb_svf_mux;

  localparam int NV = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_valid = 1'b0;
  logic [23:0]   audio_in = '0;
  logic [8:0]    mode = '0;
  logic [10:0]   alpha1 = '0;
  logic [1:0]    alpha2 = '0;
  logic [23:0]   audio_out;
  logic          out_valid;
  logic          busy;
  logic          overrun;

  svf_mux dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .audio_in     (audio_in),
    .mode         (mode),
    .alpha1       (alpha1),
    .alpha2       (alpha2),
    .audio_out    (audio_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state and current pass stimulus.
  int m_bp [NV];
  int m_lp [NV];
  int cur_in [NV];
  int cur_md [NV];
  int cur_a1;
  int cur_a2;
  int exp_out [NV];

  typedef struct {
    int ins [NV];
    int md  [NV];
    int a1;
    int a2;
    int ex  [NV];
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  function automatic int sat16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  function automatic int voice_out(input int vi);
    logic [7:0] b;
    b = audio_out[vi*8 +: 8];
    return int'($signed(b));
  endfunction

  // One filter pass over all voices, straight from the equations.
  task automatic model_pass();
    for (int vi = 0; vi < NV; vi++) begin
      longint q;
      int hp, bpn, lpn;
      longint mix;
      q = 0;
      if ((cur_a2 >> 1) & 1) q += m_bp[vi] >>> 1;
      if (cur_a2 & 1)        q += m_bp[vi] >>> 2;
      hp  = sat16(longint'(cur_in[vi]) * 256 - m_lp[vi] - q);
      bpn = sat16(longint'(m_bp[vi]) + ((longint'(hp) * cur_a1) >>> 14));
      lpn = sat16(longint'(m_lp[vi]) + ((longint'(bpn) * cur_a1) >>> 14));
      mix = 0;
      if (cur_md[vi] & 1) mix += hp;
      if (cur_md[vi] & 2) mix += bpn;
      if (cur_md[vi] & 4) mix += lpn;
      exp_out[vi] = (cur_md[vi] == 0) ? cur_in[vi] : (sat16(mix) >>> 8);
      m_bp[vi] = bpn;
      m_lp[vi] = lpn;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int vi = 0; vi < NV; vi++) begin
      m_bp[vi] = 0;
      m_lp[vi] = 0;
    end
  endtask

  task automatic drive_cur();
    for (int vi = 0; vi < NV; vi++) begin
      audio_in[vi*8 +: 8] = 8'(cur_in[vi]);
      mode[vi*3 +: 3]     = 3'(cur_md[vi]);
    end
    alpha1 = 11'(cur_a1);
    alpha2 = 2'(cur_a2);
  endtask

  // Start a pass, scramble the inputs, and wait (bounded) for out_valid.
  task automatic do_pass(output int lat);
    @(negedge clk);
    drive_cur();
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    audio_in = 24'($urandom);
    mode     = 9'($urandom);
    alpha1   = 11'($urandom);
    alpha2   = 2'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic set_row(input int i, input int i0, input int i1, input int i2,
                         input int d0, input int d1, input int d2, input int a1, input int a2,
                         input int e0, input int e1, input int e2);
    tbl[i].ins[0] = i0; tbl[i].ins[1] = i1; tbl[i].ins[2] = i2;
    tbl[i].md[0]  = d0; tbl[i].md[1]  = d1; tbl[i].md[2]  = d2;
    tbl[i].a1 = a1;
    tbl[i].a2 = a2;
    tbl[i].ex[0] = e0; tbl[i].ex[1] = e1; tbl[i].ex[2] = e2;
  endtask

  task automatic load_step();
    cur_in[0] = 100; cur_in[1] = 100; cur_in[2] = 0;
    cur_md[0] = 2;   cur_md[1] = 4;   cur_md[2] = 0;
    cur_a1 = 2047;
    cur_a2 = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cnt_v, cnt_o;

    set_row(0, 64, -50, 100, 1, 4, 0, 0, 0, 64, 0, 100);
    set_row(1, 100, 100, 0, 2, 4, 0, 2047, 0, 12, 1, 0);
    set_row(2, 127, -128, 0, 3, 1, 0, 2047, 0, 127, -128, 0);
    set_row(3, 100, -100, 50, 1, 7, 0, 2047, 3, 100, -115, 50);

    // Reset values, and no out_valid without sample_valid.
    do_reset();
    check("reset audio_out", int'(audio_out), 0);
    check("reset busy", int'(busy), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset overrun", int'(overrun), 0);
    cnt_v = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) cnt_v++;
    end
    check("idle out_valid count", cnt_v, 0);

    // Fixed vectors, each from the reset state.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      for (int vi = 0; vi < NV; vi++) begin
        cur_in[vi] = tbl[i].ins[vi];
        cur_md[vi] = tbl[i].md[vi];
      end
      cur_a1 = tbl[i].a1;
      cur_a2 = tbl[i].a2;
      do_pass(lat);
      check($sformatf("row%0d latency", i), lat, 7);
      check($sformatf("row%0d busy in done", i), int'(busy), 1);
      for (int vi = 0; vi < NV; vi++)
        check($sformatf("row%0d voice%0d", i, vi), voice_out(vi), tbl[i].ex[vi]);
      @(negedge clk);
      check($sformatf("row%0d out_valid width", i), int'(out_valid), 0);
      check($sformatf("row%0d busy after", i), int'(busy), 0);
    end

    // Overrun mid-pass and in the DONE cycle: both dropped, one pass, one out_valid.
    do_reset();
    load_step();
    @(negedge clk);
    drive_cur();
    sample_valid = 1'b1;
    cnt_v = 0;
    cnt_o = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (overrun) cnt_o++;
      if (out_valid) begin
        cnt_v++;
        check("overrun pass cycle", c, 7);
        check("overrun voice0", voice_out(0), 12);
        check("overrun voice1", voice_out(1), 1);
      end
      if (c == 10) check("overrun busy idle", int'(busy), 0);
      sample_valid = (c == 3 || c == 7);
    end
    check("overrun pulses", cnt_o, 2);
    check("overrun out_valid count", cnt_v, 1);

    // Reset at cycle 4 of a pass aborts it; state is cleared for the rerun.
    do_reset();
    load_step();
    @(negedge clk);
    drive_cur();
    sample_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      if (c == 4) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    cnt_v = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) cnt_v++;
    end
    check("abort out_valid count", cnt_v, 0);
    check("abort audio_out", int'(audio_out), 0);
    check("abort busy", int'(busy), 0);
    load_step();
    do_pass(lat);
    check("rerun latency", lat, 7);
    check("rerun voice0", voice_out(0), 12);
    check("rerun voice1", voice_out(1), 1);

    // Random back-to-back passes against the model, state carried across passes.
    do_reset();
    for (int p = 0; p < 40; p++) begin
      for (int vi = 0; vi < NV; vi++) begin
        cur_in[vi] = (p % 5 == 0) ? ((($urandom & 1) != 0) ? 127 : -128)
                                  : int'($urandom_range(0, 255)) - 128;
        cur_md[vi] = int'($urandom_range(0, 7));
      end
      cur_a1 = (p % 4 == 0) ? 2047 : int'($urandom_range(0, 2047));
      cur_a2 = int'($urandom_range(0, 3));
      model_pass();
      do_pass(lat);
      check($sformatf("rand%0d latency", p), lat, 7);
      for (int vi = 0; vi < NV; vi++)
        check($sformatf("rand%0d voice%0d", p, vi), voice_out(vi), exp_out[vi]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
